// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM/WB inputs, hazard controls,
// and register-file write port / status outputs.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             stall;
  logic             flush;
  logic             mem_valid;
  logic             mem_RFWr;
  logic [4:0]       mem_rd;
  logic [1:0]       mem_WDSel;
  logic [XLEN-1:0]  mem_alu_out;
  logic [XLEN-1:0]  mem_pc;
  logic [XLEN-1:0]  mem_dout;
  logic [2:0]       mem_ld_type;
  logic             RFWr;
  logic [4:0]       WBSel;
  logic [XLEN-1:0]  WD;
  logic             wb_valid;
  logic [CNT_W-1:0] instret;
  logic             ld_misalign;

  modport slave (
    input  stall, flush, mem_valid, mem_RFWr,
    input  mem_rd, mem_WDSel, mem_alu_out,
    input  mem_pc, mem_dout, mem_ld_type,
    output RFWr, WBSel, WD, wb_valid,
    output instret, ld_misalign
  );

  modport master (
    output stall, flush, mem_valid, mem_RFWr,
    output mem_rd, mem_WDSel, mem_alu_out,
    output mem_pc, mem_dout, mem_ld_type,
    input  RFWr, WBSel, WD, wb_valid,
    input  instret, ld_misalign
  );
endinterface

// File: rtl/wb_stage.sv
// RV32I write-back stage: MEM/WB register, load extraction,
// write-back mux, retired counter and misaligned-load flag.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave wb
);
  logic             v_q;
  logic             rfwr_q;
  logic [4:0]       rd_q;
  logic [1:0]       wdsel_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  dout_q;
  logic [2:0]       ldt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mis_q;

  logic [1:0]       off;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [XLEN-1:0]  ld_data;
  logic             ld_ok;
  logic             is_ld;
  logic             is_lb, is_lh, is_lw;
  logic             is_lbu, is_lhu;
  logic             misal;
  logic [XLEN-1:0]  wd;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q     <= 1'b0;
      rfwr_q  <= 1'b0;
      rd_q    <= '0;
      wdsel_q <= '0;
      alu_q   <= '0;
      pc_q    <= '0;
      dout_q  <= '0;
      ldt_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (wb.flush) begin
        v_q <= 1'b0;
      end else if (!wb.stall) begin
        v_q     <= wb.mem_valid;
        rfwr_q  <= wb.mem_RFWr;
        rd_q    <= wb.mem_rd;
        wdsel_q <= wb.mem_WDSel;
        alu_q   <= wb.mem_alu_out;
        pc_q    <= wb.mem_pc;
        dout_q  <= wb.mem_dout;
        ldt_q   <= wb.mem_ld_type;
      end
      if (v_q && !wb.stall)
        cnt_q <= cnt_q + 1'b1;
      if (misal)
        mis_q <= 1'b1;
    end
  end

  assign off    = alu_q[1:0];
  assign is_ld  = (wdsel_q == 2'b01);
  assign is_lb  = (ldt_q == 3'b000);
  assign is_lh  = (ldt_q == 3'b001);
  assign is_lw  = (ldt_q == 3'b010);
  assign is_lbu = (ldt_q == 3'b100);
  assign is_lhu = (ldt_q == 3'b101);
  assign half_s = off[1] ? dout_q[31:16]
                         : dout_q[15:0];

  always_comb begin
    byte_s = dout_q[7:0];
    unique case (off)
      2'd0: byte_s = dout_q[7:0];
      2'd1: byte_s = dout_q[15:8];
      2'd2: byte_s = dout_q[23:16];
      2'd3: byte_s = dout_q[31:24];
    endcase
  end

  always_comb begin
    ld_data = '0;
    ld_ok   = 1'b1;
    unique case (1'b1)
      is_lb:  ld_data = {{24{byte_s[7]}}, byte_s};
      is_lbu: ld_data = {24'd0, byte_s};
      is_lh:  ld_data = {{16{half_s[15]}}, half_s};
      is_lhu: ld_data = {16'd0, half_s};
      is_lw:  ld_data = dout_q;
      default: ld_ok  = 1'b0;
    endcase
  end

  assign misal = v_q & is_ld &
                 (((is_lh | is_lhu) & off[0]) |
                  (is_lw & (off != 2'd0)));

  always_comb begin
    wd = '0;
    unique case (wdsel_q)
      2'b00: wd = alu_q;
      2'b01: wd = (misal | !ld_ok) ? '0 : ld_data;
      2'b10: wd = pc_q + XLEN'(4);
      2'b11: wd = '0;
    endcase
  end

  // bad ld_type also blocks the write, not just misalignment
  assign wb.RFWr        = v_q & rfwr_q & (rd_q != 5'd0)
                          & ~misal & ~(is_ld & ~ld_ok);
  assign wb.WBSel       = rd_q;
  assign wb.WD          = wd;
  assign wb.wb_valid    = v_q;
  assign wb.instret     = cnt_q;
  assign wb.ld_misalign = mis_q;
endmodule
